maze_pixel_gen: RTL and testbench

- Upstream pixel source for the VGA timing controller.
- Takes the controller's registered row_addr/col_addr/rdn scan outputs and returns a 12-bit bbbb_gggg_rrrr pixel for the controller's d_in.
- Renders a tile-based maze from an internal tile-map RAM written by game logic, overlays the player sprite, and blinks the exit tile.
- Player position is double-buffered and committed once per frame in vertical blank, so the frame never tears.

---
 rtl/maze_pixel_gen_if.sv | 32 +++
 rtl/maze_pixel_gen.sv | 187 ++++++++++++++++++
 tb/tb_maze_pixel_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pixel_gen_if.sv
// Scan, tile-map write, player-position and pixel-return signals between the
//   VGA controller / game logic side (master) and maze_pixel_gen (slave).
// No handshake: every signal is sampled on each vga_clk edge, so nothing ever stalls.
// Ports: row_addr/col_addr/rdn scan in; map_we/map_waddr/map_wdata tile writes;
//   player_x/player_y/pos_valid position requests; pixel_out/frame_tick returned.
interface maze_pixel_gen_if;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        map_we;
  logic [10:0] map_waddr;
  logic [1:0]  map_wdata;
  logic [5:0]  player_x;
  logic [4:0]  player_y;
  logic        pos_valid;
  logic [11:0] pixel_out;
  logic        frame_tick;

  modport master (
    output row_addr, col_addr, rdn,
    output map_we, map_waddr, map_wdata,
    output player_x, player_y, pos_valid,
    input  pixel_out, frame_tick
  );

  modport slave (
    input  row_addr, col_addr, rdn,
    input  map_we, map_waddr, map_wdata,
    input  player_x, player_y, pos_valid,
    output pixel_out, frame_tick
  );
endinterface

// File: rtl/maze_pixel_gen.sv
// Tile-map maze renderer with player overlay and blinking exit tile for a VGA controller.
// Latency: fixed 2 vga_clk from row_addr/col_addr/rdn to pixel_out.
// Backpressure: none; one pixel accepted and produced every cycle.
// Ports: vga_clk, rst_n (async active-low); pix_if slave modport carrying the scan
//   inputs, tile-map write port, player position request and pixel/frame_tick outputs.
module maze_pixel_gen #(
  parameter int MAP_W     = 40,
  parameter int MAP_H     = 30,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int BLINK_BIT = 4
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  maze_pixel_gen_if.slave  pix_if
);

  localparam int          MAP_N   = MAP_W * MAP_H;
  localparam logic [10:0] MAP_N_L = 11'(MAP_N);

  localparam logic [1:0] TILE_FLOOR = 2'd0;
  localparam logic [1:0] TILE_WALL  = 2'd1;
  localparam logic [1:0] TILE_EXIT  = 2'd2;
  localparam logic [1:0] TILE_TRAP  = 2'd3;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_PLAYER = 12'h0FF;
  localparam logic [11:0] COL_WALL   = 12'h666;
  localparam logic [11:0] COL_EXIT   = 12'h0F0;
  localparam logic [11:0] COL_TRAP   = 12'h00F;

  // ---------------------------------------------------------------------------
  // S0: tile address, blank and overlay decode from the raw scan position
  // ---------------------------------------------------------------------------
  logic [4:0]  tile_r;
  logic [5:0]  tile_c;
  logic [10:0] rd_addr;

  assign tile_r = pix_if.row_addr[8:4];
  assign tile_c = pix_if.col_addr[9:4];
  // r*40 as (r<<5)+(r<<3): a shift-add, no multiplier needed.
  assign rd_addr = {1'b0, tile_r, 5'b0_0000} + {3'b000, tile_r, 3'b000} + {5'b0_0000, tile_c};

  logic [5:0]  active_x_q, active_x_d;
  logic [4:0]  active_y_q, active_y_d;
  logic [5:0]  shadow_x_q, shadow_x_d;
  logic [4:0]  shadow_y_q, shadow_y_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        scan_c_q;
  logic        tick_q;

  logic        blank_d, hit_d;
  logic        scan_c, commit;
  logic        pos_ok;

  always_comb begin
    blank_d = pix_if.rdn | (pix_if.col_addr >= 10'd640) | (pix_if.row_addr >= 9'd480);
    hit_d   = (tile_c == active_x_q) && (tile_r == active_y_q);
  end

  // ---------------------------------------------------------------------------
  // Tile-map RAM: 1200x2, synchronous write, synchronous read-first read.
  // Not reset; blank flags mask whatever it returns until game logic fills it.
  // ---------------------------------------------------------------------------
  logic [1:0] map_mem [MAP_N];
  logic [1:0] tile_q;

  always_ff @(posedge vga_clk) begin
    if (pix_if.map_we && (pix_if.map_waddr < MAP_N_L)) begin
      map_mem[pix_if.map_waddr] <= pix_if.map_wdata;
    end
    // Scan positions outside the image can address past the map; those are
    // blanked anyway, so return floor rather than read off the end.
    if (rd_addr < MAP_N_L) begin
      tile_q <= map_mem[rd_addr];
    end else begin
      tile_q <= TILE_FLOOR;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: side-band flags aligned with the RAM read data
  // ---------------------------------------------------------------------------
  logic       blank_q;
  logic       hit_q;
  logic [3:0] ox_q;
  logic [3:0] oy_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b1;
      hit_q   <= 1'b0;
      ox_q    <= 4'd0;
      oy_q    <= 4'd0;
    end else begin
      blank_q <= blank_d;
      hit_q   <= hit_d;
      ox_q    <= pix_if.col_addr[3:0];
      oy_q    <= pix_if.row_addr[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: colour select, highest priority first
  // ---------------------------------------------------------------------------
  logic [11:0] pix_q, pix_d;
  logic        inset;

  always_comb begin
    // Sprite is inset 2 pixels on every side so the underlying tile frames it.
    inset = (ox_q >= 4'd2) && (ox_q <= 4'd13) && (oy_q >= 4'd2) && (oy_q <= 4'd13);
    pix_d = COL_BLACK;
    if (blank_q) begin
      pix_d = COL_BLACK;
    end else if (hit_q && inset) begin
      pix_d = COL_PLAYER;
    end else begin
      case (tile_q)
        TILE_WALL: pix_d = COL_WALL;
        TILE_EXIT: pix_d = frame_cnt_q[BLINK_BIT] ? COL_BLACK : COL_EXIT;
        TILE_TRAP: pix_d = COL_TRAP;
        default:   pix_d = COL_BLACK;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= COL_BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Position double buffer and once-per-frame commit
  // ---------------------------------------------------------------------------
  always_comb begin
    // First blank line below the image; only the rising edge commits, so a
    // condition held across the whole line still commits once.
    scan_c = pix_if.rdn && (pix_if.row_addr == 9'd480);
    commit = scan_c && !scan_c_q;
    pos_ok = pix_if.pos_valid && (pix_if.player_x < 6'(MAP_W)) && (pix_if.player_y < 5'(MAP_H));

    active_x_d  = active_x_q;
    active_y_d  = active_y_q;
    frame_cnt_d = frame_cnt_q;
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;

    // Commit reads the shadow as it stood before this edge, so a request on the
    // commit cycle itself lands one frame later.
    if (commit) begin
      active_x_d  = shadow_x_q;
      active_y_d  = shadow_y_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
    if (pos_ok) begin
      shadow_x_d = pix_if.player_x;
      shadow_y_d = pix_if.player_y;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_x_q  <= 6'(START_X);
      active_y_q  <= 5'(START_Y);
      shadow_x_q  <= 6'(START_X);
      shadow_y_q  <= 5'(START_Y);
      frame_cnt_q <= 8'd0;
      scan_c_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      active_x_q  <= active_x_d;
      active_y_q  <= active_y_d;
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      frame_cnt_q <= frame_cnt_d;
      scan_c_q    <= scan_c;
      tick_q      <= commit;
    end
  end

  assign pix_if.pixel_out  = pix_q;
  assign pix_if.frame_tick = tick_q;

endmodule

// File: tb/tb_maze_pixel_gen.sv
// Bench for maze_pixel_gen: directed vector table, hand-written frame/reset/blink
//   sequences and randomized scan traffic, all checked against a behavioural model.
module tb_maze_pixel_gen;

  logic vga_clk = 1'b0;
  logic rst_n;

  maze_pixel_gen_if bus ();

  maze_pixel_gen dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .pix_if  (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  int m_map [1200];
  int m_sx, m_sy, m_ax, m_ay, m_fcnt;
  bit m_cprev;
  bit p_blank, p_hit;
  int p_tile, p_ox, p_oy;
  logic [11:0] m_pix;
  bit m_tick;

  function automatic logic [11:0] colour(bit blank, bit hit, int ox, int oy, int tile, int fcnt);
    if (blank) return 12'h000;
    if (hit && ox >= 2 && ox <= 13 && oy >= 2 && oy <= 13) return 12'h0FF;
    case (tile)
      1: return 12'h666;
      2: return ((fcnt / 16) % 2 == 0) ? 12'h0F0 : 12'h000;
      3: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    m_sx = 1; m_sy = 1; m_ax = 1; m_ay = 1;
    m_fcnt = 0; m_cprev = 0;
    p_blank = 1; p_hit = 0; p_tile = 0; p_ox = 0; p_oy = 0;
    m_pix = 12'h000; m_tick = 0;
  endtask

  task automatic model_edge();
    int row, col, idx;
    bit c_now;
    row = int'(bus.row_addr);
    col = int'(bus.col_addr);
    m_pix = colour(p_blank, p_hit, p_ox, p_oy, p_tile, m_fcnt);
    p_blank = bus.rdn || col >= 640 || row >= 480;
    idx = (row / 16) * 40 + col / 16;
    p_tile = (idx < 1200) ? m_map[idx] : 0;
    p_ox = col % 16;
    p_oy = row % 16;
    p_hit = (col / 16 == m_ax) && (row / 16 == m_ay);
    c_now = bus.rdn && row == 480;
    m_tick = c_now && !m_cprev;
    if (m_tick) begin
      m_ax = m_sx; m_ay = m_sy;
      m_fcnt = (m_fcnt + 1) % 256;
    end
    if (bus.pos_valid && int'(bus.player_x) < 40 && int'(bus.player_y) < 30) begin
      m_sx = int'(bus.player_x); m_sy = int'(bus.player_y);
    end
    m_cprev = c_now;
    if (bus.map_we && int'(bus.map_waddr) < 1200) m_map[int'(bus.map_waddr)] = int'(bus.map_wdata);
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    cyc++;
    if (chk_en) begin
      check("model_pix", bus.pixel_out, m_pix);
      check("model_tick", {11'd0, bus.frame_tick}, {11'd0, m_tick});
    end
  endtask

  task automatic idle();
    bus.row_addr = 9'd0; bus.col_addr = 10'd0; bus.rdn = 1'b1;
  endtask

  task automatic wr(input int addr, input int code);
    bus.map_we = 1'b1; bus.map_waddr = 11'(addr); bus.map_wdata = 2'(code);
    step();
    bus.map_we = 1'b0;
  endtask

  task automatic probe(input string name, input int row, input int col, input bit rdn, input logic [11:0] exp);
    bus.row_addr = 9'(row); bus.col_addr = 10'(col); bus.rdn = rdn;
    step();
    idle();
    step();
    check(name, bus.pixel_out, exp);
  endtask

  task automatic setpos(input int x, input int y);
    bus.player_x = 6'(x); bus.player_y = 5'(y); bus.pos_valid = 1'b1;
    step();
    bus.pos_valid = 1'b0;
  endtask

  task automatic commit_frame();
    bus.row_addr = 9'd480; bus.rdn = 1'b1;
    step();
    idle();
    step();
  endtask

  typedef struct {
    int          row;
    int          col;
    bit          rdn;
    logic [11:0] exp;
  } vec_t;

  vec_t vt [13];
  int ticks;

  initial begin
    // player (1,1), frame_cnt 0; tile (3,2) wall, (1,1) trap, (20,10) exit, (39,29) wall
    vt[0]  = '{40,  56,  1'b0, 12'h666};
    vt[1]  = '{40,  70,  1'b0, 12'h000};
    vt[2]  = '{21,  21,  1'b0, 12'h0FF};
    vt[3]  = '{17,  21,  1'b0, 12'h00F};
    vt[4]  = '{29,  21,  1'b0, 12'h0FF};
    vt[5]  = '{30,  21,  1'b0, 12'h00F};
    vt[6]  = '{21,  18,  1'b0, 12'h0FF};
    vt[7]  = '{21,  17,  1'b0, 12'h00F};
    vt[8]  = '{40,  56,  1'b1, 12'h000};
    vt[9]  = '{40,  700, 1'b0, 12'h000};
    vt[10] = '{490, 56,  1'b0, 12'h000};
    vt[11] = '{165, 325, 1'b0, 12'h0F0};
    vt[12] = '{479, 639, 1'b0, 12'h666};

    rst_n = 1'b1;
    idle();
    bus.map_we = 1'b0; bus.map_waddr = 11'd0; bus.map_wdata = 2'd0;
    bus.player_x = 6'd0; bus.player_y = 5'd0; bus.pos_valid = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_pix", bus.pixel_out, 12'h000);
    check("reset_tick", {11'd0, bus.frame_tick}, 12'h000);
    repeat (2) @(posedge vga_clk);
    #2 rst_n = 1'b1;
    chk_en = 1;

    for (int i = 0; i < 1200; i++) wr(i, 0);
    wr(83, 1);
    wr(41, 3);
    wr(420, 2);
    wr(1199, 1);
    wr(1250, 3);  // out of range, must be dropped

    for (int i = 0; i < 13; i++)
      probe($sformatf("vec%0d", i), vt[i].row, vt[i].col, vt[i].rdn, vt[i].exp);

    // position request mid-frame does not move the overlay
    bus.row_addr = 9'd100; bus.col_addr = 10'd100; bus.rdn = 1'b0;
    setpos(5, 7);
    probe("hold_old", 21, 21, 1'b0, 12'h0FF);
    probe("hold_new", 117, 85, 1'b0, 12'h000);

    bus.row_addr = 9'd480; bus.rdn = 1'b1;
    step();
    check("tick_pulse", {11'd0, bus.frame_tick}, 12'h001);
    step();
    check("tick_single", {11'd0, bus.frame_tick}, 12'h000);
    idle();
    step();
    probe("commit_new", 117, 85, 1'b0, 12'h0FF);
    probe("commit_old", 21, 21, 1'b0, 12'h00F);

    // commit condition held for a whole line: one tick only
    ticks = 0;
    bus.row_addr = 9'd480; bus.rdn = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      ticks += int'(bus.frame_tick);
    end
    idle();
    step();
    check("held_ticks", 12'(ticks), 12'd1);

    setpos(40, 3);
    commit_frame();
    probe("bad_x_drop", 117, 85, 1'b0, 12'h0FF);

    // request coincident with the commit edge
    setpos(2, 3);
    bus.row_addr = 9'd480; bus.rdn = 1'b1;
    bus.player_x = 6'd8; bus.player_y = 5'd9; bus.pos_valid = 1'b1;
    step();
    bus.pos_valid = 1'b0;
    idle();
    step();
    probe("coinc_old", 53, 37, 1'b0, 12'h0FF);
    probe("coinc_notyet", 149, 133, 1'b0, 12'h000);
    commit_frame();
    probe("coinc_new", 149, 133, 1'b0, 12'h0FF);

    // asynchronous reset during an active line on a wall pixel
    bus.row_addr = 9'd40; bus.col_addr = 10'd56; bus.rdn = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_pix", bus.pixel_out, 12'h000);
    check("arst_tick", {11'd0, bus.frame_tick}, 12'h000);
    step();
    #2 rst_n = 1'b1;
    step();
    check("arst_gap", bus.pixel_out, 12'h000);
    step();
    check("arst_resume", bus.pixel_out, 12'h666);
    idle();
    step();
    probe("arst_start", 21, 21, 1'b0, 12'h0FF);

    // exit blink over 32 frames
    probe("blink0", 165, 325, 1'b0, 12'h0F0);
    repeat (16) commit_frame();
    probe("blink16", 165, 325, 1'b0, 12'h000);
    repeat (16) commit_frame();
    probe("blink32", 165, 325, 1'b0, 12'h0F0);

    // randomized scan, map and position traffic
    for (int i = 0; i < 3000; i++) begin
      int r, row, col, idx;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        row = 480; col = int'($urandom_range(0, 799));
        bus.rdn = 1'b1;
      end else begin
        if (r < 33) begin
          row = m_ay * 16 + int'($urandom_range(0, 15));
          col = m_ax * 16 + int'($urandom_range(0, 15));
        end else begin
          row = int'($urandom_range(0, 524));
          col = int'($urandom_range(0, 799));
        end
        bus.rdn = (row >= 480 || col >= 640) ? 1'b1 : ($urandom_range(0, 9) == 0);
      end
      bus.row_addr = 9'(row);
      bus.col_addr = 10'(col);
      idx = (row / 16) * 40 + col / 16;
      bus.map_we = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0 && idx < 1200) bus.map_waddr = 11'(idx);
      else bus.map_waddr = 11'($urandom_range(0, 1299));
      bus.map_wdata = 2'($urandom_range(0, 3));
      bus.pos_valid = ($urandom_range(0, 19) == 0);
      bus.player_x = 6'($urandom_range(0, 45));
      bus.player_y = 5'($urandom_range(0, 31));
      step();
    end
    bus.map_we = 1'b0;
    bus.pos_valid = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
